// File: rtl/trail_framebuffer_if.sv
// trail_framebuffer_if: plot, query and clear signals between game logic and the shadow framebuffer.
interface trail_framebuffer_if #(parameter int COLOUR_BITS = 3);
  logic [7:0] x;
  logic [6:0] y;
  logic [COLOUR_BITS-1:0] colour;
  logic plot;
  logic wr_ready;
  logic q_req;
  logic [7:0] q_x;
  logic [6:0] q_y;
  logic q_ready;
  logic q_valid;
  logic [COLOUR_BITS-1:0] q_colour;
  logic q_oob;
  logic clear_req;
  logic busy;
  logic clear_done;
`ifdef TRAIL_FRAMEBUFFER_COLLISION_EN
  logic coll_valid;
  logic [7:0] coll_x;
  logic [6:0] coll_y;
  logic [COLOUR_BITS-1:0] coll_old;
`endif
  modport master (
    output x, y, colour, plot, q_req, q_x, q_y, clear_req,
    input wr_ready, q_ready, q_valid, q_colour, q_oob, busy, clear_done
`ifdef TRAIL_FRAMEBUFFER_COLLISION_EN
    , input coll_valid, coll_x, coll_y, coll_old
`endif
  );
  modport slave (
    input x, y, colour, plot, q_req, q_x, q_y, clear_req,
    output wr_ready, q_ready, q_valid, q_colour, q_oob, busy, clear_done
`ifdef TRAIL_FRAMEBUFFER_COLLISION_EN
    , output coll_valid, coll_x, coll_y, coll_old
`endif
  );
endinterface

// File: rtl/trail_framebuffer.sv
// trail_framebuffer: shadow copy of the playfield with query port and clear sequencer; TRAIL_FRAMEBUFFER_COLLISION_EN adds collision reporting.
module trail_framebuffer #(
  parameter int WIDTH = 160,
  parameter int HEIGHT = 120,
  parameter int COLOUR_BITS = 3,
  parameter logic [COLOUR_BITS-1:0] CLEAR_COLOUR = '0
) (
  input logic CLOCK_50,
  input logic resetn,
  trail_framebuffer_if.slave bus
);
  localparam int DEPTH = WIDTH * HEIGHT;
  localparam int AW = 15;
  typedef enum logic {CLEAR, IDLE} state_t;
  state_t state, state_nx;
  logic [AW-1:0] cnt, cnt_nx;
  logic [COLOUR_BITS-1:0] mem [0:DEPTH-1];
  logic idle, last, plot_wr, we, q_acc, q1_v, q1_oob, clear_done;
  logic [AW-1:0] waddr, q1_addr;
  logic [COLOUR_BITS-1:0] wdata, q_colour;
  logic q_valid, q_oob;
  function automatic logic [AW-1:0] addr_of(input logic [7:0] cx, input logic [6:0] cy);
    return (WIDTH == 160) ? (AW'(cy) << 7) + (AW'(cy) << 5) + AW'(cx) : AW'(int'(cy) * WIDTH) + AW'(cx);
  endfunction
  function automatic logic in_range(input logic [7:0] cx, input logic [6:0] cy);
    return (int'(cx) < WIDTH) && (int'(cy) < HEIGHT);
  endfunction
  assign idle = state == IDLE;
  assign last = cnt == AW'(DEPTH - 1);
  assign plot_wr = idle && bus.plot && in_range(bus.x, bus.y);
  assign q_acc = idle && bus.q_req;
  assign we = !idle || plot_wr;
  assign waddr = idle ? addr_of(bus.x, bus.y) : cnt;
  assign wdata = idle ? bus.colour : CLEAR_COLOUR;
  assign bus.wr_ready = idle;
  assign bus.q_ready = idle;
  assign bus.busy = !idle;
  assign bus.clear_done = clear_done;
  assign bus.q_valid = q_valid;
  assign bus.q_colour = q_colour;
  assign bus.q_oob = q_oob;
  always_comb begin
    state_nx = idle ? (bus.clear_req ? CLEAR : IDLE) : (last ? IDLE : CLEAR);
    cnt_nx = (!idle && !last) ? cnt + 1'b1 : '0;
  end
  always_ff @(posedge CLOCK_50)
    if (we) mem[waddr] <= wdata;
  always_ff @(posedge CLOCK_50 or negedge resetn)
    if (!resetn) begin
      state <= CLEAR;
      cnt <= '0;
      clear_done <= 1'b0;
      q1_v <= 1'b0;
      q1_oob <= 1'b0;
      q1_addr <= '0;
      q_valid <= 1'b0;
      q_oob <= 1'b0;
      q_colour <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      clear_done <= !idle && last;
      q1_v <= q_acc;
      if (q_acc) begin
        q1_oob <= !in_range(bus.q_x, bus.q_y);
        q1_addr <= addr_of(bus.q_x, bus.q_y);
      end
      q_valid <= q1_v;
      if (q1_v) begin
        q_oob <= q1_oob;
        // write-first: a write landing on the read edge is forwarded
        q_colour <= q1_oob ? '0 : (we && waddr == q1_addr) ? wdata : mem[q1_addr];
      end
    end
`ifdef TRAIL_FRAMEBUFFER_COLLISION_EN
  logic coll_valid;
  logic [7:0] coll_x;
  logic [6:0] coll_y;
  logic [COLOUR_BITS-1:0] coll_old;
  assign bus.coll_valid = coll_valid;
  assign bus.coll_x = coll_x;
  assign bus.coll_y = coll_y;
  assign bus.coll_old = coll_old;
  always_ff @(posedge CLOCK_50 or negedge resetn)
    if (!resetn) begin
      coll_valid <= 1'b0;
      coll_x <= '0;
      coll_y <= '0;
      coll_old <= '0;
    end else begin
      coll_valid <= plot_wr && mem[waddr] != CLEAR_COLOUR;
      if (plot_wr && mem[waddr] != CLEAR_COLOUR) begin
        coll_x <= bus.x;
        coll_y <= bus.y;
        coll_old <= mem[waddr];
      end
    end
`endif
endmodule

// File: tb/tb_trail_framebuffer.sv
// tb_trail_framebuffer: directed bench with a query scoreboard for trail_framebuffer.
module tb_trail_framebuffer;
  logic CLOCK_50 = 1'b0;
  logic resetn;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  typedef struct {
    logic [2:0] col;
    logic oob;
    int due;
  } exp_t;
  exp_t sb[$];
  always #5 CLOCK_50 = ~CLOCK_50;
  always @(posedge CLOCK_50) cyc <= cyc + 1;
  trail_framebuffer_if #(.COLOUR_BITS(3)) bus ();
  trail_framebuffer dut (.CLOCK_50(CLOCK_50), .resetn(resetn), .bus(bus));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    exp_t e;
    @(negedge CLOCK_50);
    if (bus.q_valid === 1'b1) begin
      if (sb.size() == 0) chk("q_unexpected", 32'(bus.q_valid), 0);
      else begin
        e = sb.pop_front();
        chk("q_colour", 32'(bus.q_colour), 32'(e.col));
        chk("q_oob", 32'(bus.q_oob), 32'(e.oob));
        chk("q_latency", cyc, e.due);
      end
    end
  endtask
  task automatic idle(input int n);
    repeat (n) tick();
  endtask
  task automatic push_q(input logic [7:0] qx, input logic [6:0] qy, input logic [2:0] col, input logic oob);
    bus.q_req = 1'b1;
    bus.q_x = qx;
    bus.q_y = qy;
    sb.push_back('{col, oob, cyc + 2});
  endtask
  task automatic query(input logic [7:0] qx, input logic [6:0] qy, input logic [2:0] col, input logic oob);
    push_q(qx, qy, col, oob);
    tick();
    bus.q_req = 1'b0;
  endtask
  task automatic write(input logic [7:0] wx, input logic [6:0] wy, input logic [2:0] col);
    bus.plot = 1'b1;
    bus.x = wx;
    bus.y = wy;
    bus.colour = col;
    tick();
    bus.plot = 1'b0;
  endtask
  task automatic wait_clear(input string tag);
    int n = 0;
    bit busy_ok = 1'b1;
    while (n < 20000) begin
      tick();
      n++;
      if (bus.clear_done === 1'b1) break;
      if (bus.busy !== 1'b1 || bus.wr_ready !== 1'b0) busy_ok = 1'b0;
    end
    bus.plot = 1'b0;
    bus.q_req = 1'b0;
    bus.clear_req = 1'b0;
    chk({tag, "_cycles"}, n, 19200);
    chk({tag, "_busy_held"}, 32'(busy_ok), 1);
    chk({tag, "_wr_ready"}, 32'(bus.wr_ready), 1);
    chk({tag, "_busy_low"}, 32'(bus.busy), 0);
    tick();
    chk({tag, "_done_pulse"}, 32'(bus.clear_done), 0);
  endtask
  initial begin
    resetn = 1'b1;
    bus.plot = 1'b1;
    bus.x = 8'd1;
    bus.y = 7'd1;
    bus.colour = 3'b111;
    bus.q_req = 1'b1;
    bus.q_x = 8'd1;
    bus.q_y = 7'd1;
    bus.clear_req = 1'b1;
    #2 resetn = 1'b0;
    idle(3);
    chk("rst_busy", 32'(bus.busy), 1);
    chk("rst_wr_ready", 32'(bus.wr_ready), 0);
    chk("rst_q_ready", 32'(bus.q_ready), 0);
    chk("rst_q_valid", 32'(bus.q_valid), 0);
    chk("rst_q_colour", 32'(bus.q_colour), 0);
    chk("rst_q_oob", 32'(bus.q_oob), 0);
    chk("rst_clear_done", 32'(bus.clear_done), 0);
`ifdef TRAIL_FRAMEBUFFER_COLLISION_EN
    chk("rst_coll_valid", 32'(bus.coll_valid), 0);
    chk("rst_coll_old", 32'(bus.coll_old), 0);
`endif
    resetn = 1'b1;
    wait_clear("clr1");
    query(1, 1, 3'b000, 1'b0);
    write(10, 20, 3'b001);
    query(10, 20, 3'b001, 1'b0);
    query(11, 20, 3'b000, 1'b0);
    idle(3);
    write(159, 119, 3'b110);
    query(159, 119, 3'b110, 1'b0);
    query(160, 5, 3'b000, 1'b1);
    write(0, 120, 3'b111);
    query(0, 0, 3'b000, 1'b0);
    query(0, 120, 3'b000, 1'b1);
    idle(3);
    push_q(5, 5, 3'b010, 1'b0);
    tick();
    bus.q_req = 1'b0;
    write(5, 5, 3'b010);
    idle(3);
    push_q(6, 6, 3'b000, 1'b0);
    tick();
    bus.q_req = 1'b0;
    tick();
    write(6, 6, 3'b010);
    idle(3);
    query(6, 6, 3'b010, 1'b0);
    query(5, 5, 3'b010, 1'b0);
    idle(3);
    query(10, 20, 3'b001, 1'b0);
    query(159, 119, 3'b110, 1'b0);
    query(11, 20, 3'b000, 1'b0);
    query(200, 100, 3'b000, 1'b1);
    idle(3);
    chk("hold_q_oob", 32'(bus.q_oob), 1);
    chk("hold_q_colour", 32'(bus.q_colour), 0);
`ifdef TRAIL_FRAMEBUFFER_COLLISION_EN
    write(30, 40, 3'b001);
    chk("coll_first", 32'(bus.coll_valid), 0);
    write(30, 40, 3'b100);
    chk("coll_valid", 32'(bus.coll_valid), 1);
    chk("coll_x", 32'(bus.coll_x), 30);
    chk("coll_y", 32'(bus.coll_y), 40);
    chk("coll_old", 32'(bus.coll_old), 1);
    tick();
    chk("coll_pulse", 32'(bus.coll_valid), 0);
`endif
    bus.clear_req = 1'b1;
    query(10, 20, 3'b001, 1'b0);
    bus.clear_req = 1'b0;
    bus.q_req = 1'b1;
    bus.q_x = 8'd10;
    bus.q_y = 7'd20;
    bus.plot = 1'b1;
    idle(5000);
    chk("mid_clear_busy", 32'(bus.busy), 1);
    bus.q_req = 1'b0;
    bus.plot = 1'b0;
    resetn = 1'b0;
    tick();
    chk("rst2_busy", 32'(bus.busy), 1);
    chk("rst2_wr_ready", 32'(bus.wr_ready), 0);
    chk("rst2_clear_done", 32'(bus.clear_done), 0);
    resetn = 1'b1;
    wait_clear("clr2");
    query(10, 20, 3'b000, 1'b0);
    query(159, 119, 3'b000, 1'b0);
    query(5, 5, 3'b000, 1'b0);
    query(6, 6, 3'b000, 1'b0);
    query(30, 40, 3'b000, 1'b0);
    idle(4);
    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/trail_framebuffer.md
Name: trail_framebuffer

Overview:
- Receiving end of the pixel-plot interface (x, y, colour, plot) that the draw sequencer drives toward the VGA adapter.
- Keeps an on-chip shadow copy of the 160x120 playfield, so game logic can read back the colour at any coordinate (trail/wall collision checks).
- Sits beside the VGA adapter, fed by the same plot bus.
- Adds a query handshake and a full-screen clear sequencer.

Parameters:
- WIDTH, 160, playfield columns; x range 0..WIDTH-1.
- HEIGHT, 120, playfield rows; y range 0..HEIGHT-1.
- COLOUR_BITS, 3, bits per stored pixel.
- CLEAR_COLOUR, 3'b000, value written by the clear sequencer.

Ports:
- CLOCK_50  in  1  system clock; all logic on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- x  in  8  plot column.
- y  in  7  plot row.
- colour  in  COLOUR_BITS  plot colour.
- plot  in  1  write request; accepted on an edge where plot && wr_ready.
- wr_ready  out  1  high when writes are accepted (IDLE only).
- q_req  in  1  query request; accepted on an edge where q_req && q_ready.
- q_x  in  8  query column.
- q_y  in  7  query row.
- q_ready  out  1  high in IDLE.
- q_valid  out  1  one-cycle pulse: q_colour/q_oob valid.
- q_colour  out  COLOUR_BITS  stored colour at the queried pixel.
- q_oob  out  1  queried coordinate out of range; q_colour forced to 0.
- clear_req  in  1  start full-screen clear.
- busy  out  1  high while clearing.
- clear_done  out  1  one-cycle pulse after the last clear write.

Behaviour:
- Storage: WIDTH*HEIGHT words of COLOUR_BITS bits; dual-port RAM (one write port, one read port).
- Address = y*WIDTH + x, 15 bits. Multiplier-free form for the default: (y<<7)+(y<<5)+x.
- In range: x<WIDTH and y<HEIGHT.
- States: CLEAR, IDLE.
- Reset (async, resetn=0):
  - state=CLEAR, clear counter=0.
  - wr_ready=0, q_ready=0, busy=1, q_valid=0, q_colour=0, q_oob=0, clear_done=0.
  - RAM contents are not reset; the automatic clear covers this.
- CLEAR:
  - Writes CLEAR_COLOUR to address counter, one address per cycle, counter 0..WIDTH*HEIGHT-1 (19200 cycles at the defaults).
  - On the edge writing the last address: counter returns to 0, state becomes IDLE, clear_done pulses for the following cycle.
  - plot, q_req and clear_req are ignored and dropped; there is no queueing.
  - Reset asserted mid-clear restarts the clear at address 0.
- IDLE:
  - wr_ready=1, q_ready=1, busy=0.
  - clear_req=1 enters CLEAR on the next edge. A plot or q_req sampled on that same edge is still accepted and completes normally.
- Write:
  - An accepted in-range plot writes colour at the accepting edge.
  - An out-of-range plot is silently dropped; RAM is unchanged.
- Query:
  - Edge N (accept): register address and range flag.
  - Edge N+1: RAM read.
  - q_valid is high during the cycle after edge N+1 (latency 2), for exactly one cycle.
  - Back-to-back queries are allowed, one per cycle, fully pipelined. A query accepted on the edge that enters CLEAR still completes.
- Read/write ordering:
  - q_colour reflects every write accepted at or before edge N+1.
  - A write to the same address on edge N+1 is forwarded (write-first).
  - A write on a later edge is not visible.
- Out-of-range query: q_oob=1 and q_colour=0 with the normal latency; no RAM access.
- q_colour and q_oob hold their last values when q_valid=0.

Optional Feature:
- Macro: TRAIL_FRAMEBUFFER_COLLISION_EN.
- With the macro defined:
  - Extra outputs: coll_valid (1), coll_x (8), coll_y (7), coll_old (COLOUR_BITS).
  - On each accepted in-range plot, the write port also reads the old word (read-old-data).
  - If old != CLEAR_COLOUR, coll_valid pulses in the cycle after the accepting edge, with that plot's x, y and the old colour.
  - Outputs reset to 0.
  - Writes during CLEAR never flag a collision.
- Without the macro: the ports do not exist and the RAM write port is write-only.

Test Plan:
1. Release reset; hold plot=1 throughout -> busy=1 for 19200 cycles, clear_done pulses once, wr_ready rises the same cycle as clear_done; nothing written during clear.
2. IDLE: plot (x=10, y=20, colour=3'b001) -> query (10,20) accepted next cycle gives q_valid exactly 2 cycles later with q_colour=001, q_oob=0. Query (11,20) gives 000.
3. Write (159,119,3'b110), then query (159,119) -> 110. Query (160,5) -> q_oob=1, q_colour=0. Write (0,120,3'b111) -> query (0,0) still returns 000.
4. Query (5,5) accepted at edge N; write (5,5,3'b010) at edge N+1 -> q_colour=010. Same write at edge N+2 -> q_colour=000.
5. Write several pixels; pulse clear_req; assert resetn=0 at counter=5000; release -> busy restarts, one full clear of 19200 cycles, then every earlier pixel reads 000.
6. With TRAIL_FRAMEBUFFER_COLLISION_EN: write (30,40,3'b001), then write (30,40,3'b100) -> coll_valid=1 one cycle after the second accept, coll_x=30, coll_y=40, coll_old=001. The first write produces no pulse.
